// File: rtl/prog_launch_pkg.sv
// prog_launch_pkg: shared types and defaults for the program launch sequencer.
// Contents:
//   state_e    - sequencer states (IDLE, LAUNCH, RUN, NEXT, FINISH)
//   DEF_*      - default parameter values for the sequencer
//   idx_width  - width of a slot index for a given slot count
package prog_launch_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Smallest width able to index depth slots; never below one bit.
  function automatic int idx_width(input int depth);
    int w;
    w = 32'sd1;
    while ((32'sd1 << w) < depth) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/launch_addr_buf.sv
// launch_addr_buf: DEPTH x ADDR_W store of program start addresses.
// Ports:
//   clock_i, reset_n_i - clock and asynchronous active-low reset (empties buffer)
//   load_i             - qualified write: store load_addr_i at slot[count]
//   load_addr_i        - address to store
//   clear_i            - qualified clear: count back to zero (wins over load)
//   rd_idx_i           - slot to read
//   rd_addr_o          - contents of slot[rd_idx_i]
//   count_o            - number of valid slots, 0..DEPTH
module launch_addr_buf
  import prog_launch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                        clock_i,
  input  logic                        reset_n_i,
  input  logic                        load_i,
  input  logic [ADDR_W-1:0]           load_addr_i,
  input  logic                        clear_i,
  input  logic [idx_width(DEPTH)-1:0] rd_idx_i,
  output logic [ADDR_W-1:0]           rd_addr_o,
  output logic [idx_width(DEPTH):0]   count_o
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [IDX_W:0] DEPTH_C   = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] COUNT_ONE = (IDX_W+1)'(32'd1);

  logic [ADDR_W-1:0] slot_r [DEPTH];
  logic [IDX_W:0]    count_r;

  // Slot array and fill count; clear wins, writes past full are dropped.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= {(IDX_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        slot_r[i] <= {ADDR_W{1'b0}};
      end
    end else if (clear_i) begin
      count_r <= {(IDX_W+1){1'b0}};
    end else if (load_i && (count_r < DEPTH_C)) begin
      slot_r[count_r[IDX_W-1:0]] <= load_addr_i;
      count_r                    <= count_r + COUNT_ONE;
    end
  end

  assign rd_addr_o = slot_r[rd_idx_i];
  assign count_o   = count_r;

endmodule

// File: rtl/prog_launch_seq.sv
// prog_launch_seq: launches each buffered program start address on the CPU in
// turn, waits for a fresh rising edge of done, and reports the elapsed cycles.
// Ports:
//   clock_i, reset_n_i          - clock, asynchronous active-low reset
//   load_valid_i/load_addr_i    - store an address in the next free slot
//   load_ready_o                - the store is accepted this cycle
//   clear_i                     - empty the buffer (only while idle)
//   go_i                        - run every stored program in order
//   cpu_start_o/cpu_start_addr_o- one-cycle start pulse and held start address
//   cpu_done_i                  - CPU done level
//   busy_o                      - sequence in progress
//   prog_idx_o                  - current or last program index
//   prog_done_o/cycles_o        - completion pulse and its cycle count (held)
//   all_done_o                  - pulse at the end of a sequence
//   timeout_o                   - sticky: the last sequence aborted a program
// Build option: define PROG_LAUNCH_TIMEOUT_EN to abort a program once its
// counter reaches TIMEOUT; otherwise RUN waits forever and timeout_o is 0.
module prog_launch_seq
  import prog_launch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clock_i,
  input  logic                        reset_n_i,
  input  logic                        load_valid_i,
  input  logic [ADDR_W-1:0]           load_addr_i,
  output logic                        load_ready_o,
  input  logic                        clear_i,
  input  logic                        go_i,
  output logic                        cpu_start_o,
  output logic [ADDR_W-1:0]           cpu_start_addr_o,
  input  logic                        cpu_done_i,
  output logic                        busy_o,
  output logic [idx_width(DEPTH)-1:0] prog_idx_o,
  output logic                        prog_done_o,
  output logic [CNT_W-1:0]            cycles_o,
  output logic                        all_done_o,
  output logic                        timeout_o
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [IDX_W:0]   DEPTH_C   = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   COUNT_ONE = (IDX_W+1)'(32'd1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cycles_r;
  logic [ADDR_W-1:0] start_addr_r;
  logic              done_q_r;
  logic              cpu_start_r;
  logic              busy_r;
  logic              prog_done_r;
  logic              all_done_r;
  logic              timeout_r;
  logic              out_en_r;

  logic [IDX_W-1:0]  rd_idx_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [IDX_W:0]    count_s;
  logic              idle_s;
  logic              load_ready_s;
  logic              clear_s;
  logic              last_s;
  logic              rise_s;
  logic              abort_s;

  assign idle_s = (state_r == ST_IDLE);

  // out_en_r keeps load_ready_o low while reset is held; go wins over a
  // same-cycle load or clear so the run always sees the list it started with.
  assign load_ready_s = out_en_r && idle_s && (count_s < DEPTH_C) && !clear_i && !go_i;
  assign clear_s      = idle_s && clear_i && !go_i;

  assign last_s = ({1'b0, idx_r} == (count_s - COUNT_ONE));
  assign rise_s = cpu_done_i && !done_q_r;

`ifdef PROG_LAUNCH_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  assign abort_s = (cnt_r >= TIMEOUT_C);
`else
  assign abort_s = 1'b0;
`endif

  // Read slot 0 for the first launch, idx+1 when stepping to the next one.
  always_comb begin
    rd_idx_s = {IDX_W{1'b0}};
    if (state_r == ST_NEXT) begin
      rd_idx_s = idx_r + IDX_ONE;
    end else begin
      rd_idx_s = {IDX_W{1'b0}};
    end
  end

  launch_addr_buf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .load_i      (load_valid_i && load_ready_s),
    .load_addr_i (load_addr_i),
    .clear_i     (clear_s),
    .rd_idx_i    (rd_idx_s),
    .rd_addr_o   (rd_addr_s),
    .count_o     (count_s)
  );

  // Sequencer FSM, per-program cycle counter and all registered outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= ST_IDLE;
      idx_r        <= {IDX_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      cycles_r     <= {CNT_W{1'b0}};
      start_addr_r <= {ADDR_W{1'b0}};
      done_q_r     <= 1'b0;
      cpu_start_r  <= 1'b0;
      busy_r       <= 1'b0;
      prog_done_r  <= 1'b0;
      all_done_r   <= 1'b0;
      timeout_r    <= 1'b0;
      out_en_r     <= 1'b0;
    end else begin
      out_en_r    <= 1'b1;
      done_q_r    <= cpu_done_i;
      cpu_start_r <= 1'b0;
      prog_done_r <= 1'b0;
      all_done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (go_i) begin
            timeout_r <= 1'b0;
            if (count_s != {(IDX_W+1){1'b0}}) begin
              state_r      <= ST_LAUNCH;
              busy_r       <= 1'b1;
              idx_r        <= {IDX_W{1'b0}};
              cpu_start_r  <= 1'b1;
              start_addr_r <= rd_addr_s;
            end else begin
              // Empty list: report the end of a zero-length run at once.
              state_r    <= ST_FINISH;
              all_done_r <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          cnt_r   <= CNT_ONE;
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
          // Only a fresh edge completes; a level left high is ignored.
          if (rise_s) begin
            prog_done_r <= 1'b1;
            cycles_r    <= cnt_r;
            state_r     <= ST_NEXT;
          end else if (abort_s) begin
            // cnt_r equals TIMEOUT on the first cycle it is reached.
            prog_done_r <= 1'b1;
            cycles_r    <= cnt_r;
            timeout_r   <= 1'b1;
            state_r     <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last_s) begin
            state_r    <= ST_FINISH;
            all_done_r <= 1'b1;
            busy_r     <= 1'b0;
          end else begin
            idx_r        <= rd_idx_s;
            state_r      <= ST_LAUNCH;
            cpu_start_r  <= 1'b1;
            start_addr_r <= rd_addr_s;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready_o     = load_ready_s;
  assign cpu_start_o      = cpu_start_r;
  assign cpu_start_addr_o = start_addr_r;
  assign busy_o           = busy_r;
  assign prog_idx_o       = idx_r;
  assign prog_done_o      = prog_done_r;
  assign cycles_o         = cycles_r;
  assign all_done_o       = all_done_r;
  assign timeout_o        = timeout_r;

endmodule

// File: tb/tb_prog_launch_seq.sv
// tb_prog_launch_seq: directed, table-driven bench for prog_launch_seq with a
// small CPU model that raises done a programmed number of cycles after start.
module tb_prog_launch_seq;

  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;

  logic              clk;
  logic              rst_n;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic              load_ready;
  logic              clear;
  logic              go;
  logic              cpu_start;
  logic [ADDR_W-1:0] cpu_start_addr;
  logic              cpu_done;
  logic              busy;
  logic [1:0]        prog_idx;
  logic              prog_done;
  logic [CNT_W-1:0]  cycles;
  logic              all_done;
  logic              timeout;

  prog_launch_seq #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock_i          (clk),
    .reset_n_i        (rst_n),
    .load_valid_i     (load_valid),
    .load_addr_i      (load_addr),
    .load_ready_o     (load_ready),
    .clear_i          (clear),
    .go_i             (go),
    .cpu_start_o      (cpu_start),
    .cpu_start_addr_o (cpu_start_addr),
    .cpu_done_i       (cpu_done),
    .busy_o           (busy),
    .prog_idx_o       (prog_idx),
    .prog_done_o      (prog_done),
    .cycles_o         (cycles),
    .all_done_o       (all_done),
    .timeout_o        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic lv; logic [7:0] addr; logic clr; logic go; logic rdy; } ld_vec_t;
  typedef struct { int addr; int dly; int cyc; int to; } run_exp_t;

  ld_vec_t  ld_tab [13];
  run_exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Monitor history (written only by the monitor).
  int start_h[$];
  int cyc_h[$];
  int idx_h[$];
  int to_h[$];
  int all_done_n = 0;
  int busy_n     = 0;
  int sb, cb, ab, bb;

  // CPU model controls (dly_arr/hold_done written only by the main flow).
  int   dly_arr [64];
  int   n_starts  = 0;
  logic hold_done = 1'b0;

  always @(negedge clk) begin
    if (cpu_start) start_h.push_back(int'(cpu_start_addr));
    if (prog_done) begin
      cyc_h.push_back(int'(cycles));
      idx_h.push_back(int'(prog_idx));
      to_h.push_back(int'(timeout));
    end
    if (all_done) all_done_n++;
    if (busy) busy_n++;
  end

  // CPU model: dly 0 means never done; hold mode keeps a high done level,
  // drops it after dly cycles and raises it again one cycle later.
  initial begin
    int d;
    cpu_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && cpu_start) begin
        d = dly_arr[n_starts];
        n_starts++;
        if (hold_done) begin
          if (d > 0) begin
            repeat (d) @(posedge clk);
            #1 cpu_done = 1'b0;
            @(posedge clk);
            #1 cpu_done = 1'b1;
          end
        end else begin
          cpu_done = 1'b0;
          if (d > 0) begin
            repeat (d) @(posedge clk);
            #1 cpu_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic mark();
    sb = start_h.size();
    cb = cyc_h.size();
    ab = all_done_n;
    bb = busy_n;
  endtask

  task automatic apply_loads(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step();
      load_valid = ld_tab[i].lv;
      load_addr  = ld_tab[i].addr;
      clear      = ld_tab[i].clr;
      go         = ld_tab[i].go;
      #1;
      check($sformatf("load_ready[%0d]", i), load_ready, ld_tab[i].rdy);
    end
    step();
    load_valid = 1'b0; load_addr = 8'd0; clear = 1'b0; go = 1'b0;
  endtask

  task automatic load_one(input int a);
    step();
    load_valid = 1'b1; load_addr = 8'(a);
    #1;
    check($sformatf("load_ready addr %0d", a), load_ready, 1);
    step();
    load_valid = 1'b0; load_addr = 8'd0;
  endtask

  task automatic clear_buf();
    step();
    clear = 1'b1;
    #1;
    check("load_ready during clear", load_ready, 0);
    step();
    clear = 1'b0;
  endtask

  // Run the stored list against exp_q and compare every launch/completion.
  task automatic run_go(input string nm, input bit with_load);
    int base;
    base = n_starts;
    for (int j = 0; j < exp_q.size(); j++) dly_arr[base + j] = exp_q[j].dly;
    mark();
    step();
    go = 1'b1;
    if (with_load) begin
      load_valid = 1'b1; load_addr = 8'd200;
      #1;
      check({nm, " load_ready with go"}, load_ready, 0);
    end
    step();
    go = 1'b0; load_valid = 1'b0; load_addr = 8'd0;
    check({nm, " start latency"}, cpu_start, 1);
    check({nm, " first addr"}, cpu_start_addr, exp_q[0].addr);
    check({nm, " busy after go"}, busy, 1);
    for (int i = 0; i < 3000 && all_done_n == ab; i++) step();
    check({nm, " all_done seen"}, all_done_n != ab, 1);
    repeat (3) step();
    check({nm, " busy at end"}, busy, 0);
    check({nm, " all_done pulses"}, all_done_n - ab, 1);
    check({nm, " starts"}, start_h.size() - sb, exp_q.size());
    check({nm, " completions"}, cyc_h.size() - cb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (sb + i < start_h.size())
        check($sformatf("%s addr[%0d]", nm, i), start_h[sb + i], exp_q[i].addr);
      if (cb + i < cyc_h.size()) begin
        check($sformatf("%s cycles[%0d]", nm, i), cyc_h[cb + i], exp_q[i].cyc);
        check($sformatf("%s idx[%0d]", nm, i), idx_h[cb + i], i);
        check($sformatf("%s timeout[%0d]", nm, i), to_h[cb + i], exp_q[i].to);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                  lv    addr    clr   go    rdy
    ld_tab[0]  = '{1'b1, 8'd5,   1'b0, 1'b0, 1'b1};
    ld_tab[1]  = '{1'b1, 8'd6,   1'b0, 1'b0, 1'b1};
    ld_tab[2]  = '{1'b1, 8'd7,   1'b1, 1'b0, 1'b0}; // clear beats load
    ld_tab[3]  = '{1'b1, 8'd10,  1'b0, 1'b0, 1'b1};
    ld_tab[4]  = '{1'b1, 8'd11,  1'b0, 1'b0, 1'b1};
    ld_tab[5]  = '{1'b1, 8'd12,  1'b0, 1'b0, 1'b1};
    ld_tab[6]  = '{1'b1, 8'd13,  1'b0, 1'b0, 1'b1};
    ld_tab[7]  = '{1'b1, 8'd14,  1'b0, 1'b0, 1'b0}; // fifth load dropped
    ld_tab[8]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0}; // still full
    ld_tab[9]  = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b0};
    ld_tab[10] = '{1'b1, 8'd0,   1'b0, 1'b0, 1'b1};
    ld_tab[11] = '{1'b1, 8'd93,  1'b0, 1'b0, 1'b1};
    ld_tab[12] = '{1'b1, 8'd138, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; load_valid = 1'b0; load_addr = 8'd0; clear = 1'b0; go = 1'b0;
    repeat (2) step();
    check("rst cpu_start", cpu_start, 0);
    check("rst start_addr", cpu_start_addr, 0);
    check("rst busy", busy, 0);
    check("rst prog_idx", prog_idx, 0);
    check("rst prog_done", prog_done, 0);
    check("rst cycles", cycles, 0);
    check("rst all_done", all_done, 0);
    check("rst timeout", timeout, 0);
    check("rst load_ready", load_ready, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Fill past capacity; only 10..13 remain, so the run shows count=4.
    apply_loads(0, 8);
    exp_q.delete();
    exp_q.push_back('{10, 3, 3, 0});
    exp_q.push_back('{11, 3, 3, 0});
    exp_q.push_back('{12, 3, 3, 0});
    exp_q.push_back('{13, 3, 3, 0});
    run_go("full4", 1'b0);

    // Main three-program sequence with a same-cycle load that must drop.
    apply_loads(9, 12);
    exp_q.delete();
    exp_q.push_back('{0,   50, 50, 0});
    exp_q.push_back('{93,  70, 70, 0});
    exp_q.push_back('{138, 30, 30, 0});
    run_go("seq3", 1'b1);
    check("seq3 timeout_o", timeout, 0);

    // done is still high: completion only on the re-raised edge (d+1).
    hold_done = 1'b1;
    exp_q.delete();
    exp_q.push_back('{0,   20, 21, 0});
    exp_q.push_back('{93,  20, 21, 0});
    exp_q.push_back('{138, 20, 21, 0});
    run_go("stuck", 1'b0);
    hold_done = 1'b0;

    // Empty buffer: all_done next cycle, never busy, no start.
    clear_buf();
    mark();
    step();
    go = 1'b1;
    step();
    go = 1'b0;
    check("empty all_done", all_done, 1);
    check("empty busy", busy, 0);
    check("empty cpu_start", cpu_start, 0);
    repeat (5) step();
    check("empty starts", start_h.size() - sb, 0);
    check("empty busy cycles", busy_n - bb, 0);
    check("empty all_done pulses", all_done_n - ab, 1);

    // Reset while the second launch pulse is on the bus.
    load_one(77);
    load_one(88);
    dly_arr[n_starts]     = 5;
    dly_arr[n_starts + 1] = 0;
    step();
    go = 1'b1;
    step();
    go = 1'b0;
    for (int i = 0; i < 100 && !(cpu_start && cpu_start_addr == 8'd88); i++) step();
    check("midrun second start", cpu_start && cpu_start_addr == 8'd88, 1);
    check("midrun cycles before rst", cycles, 5);
    #1 rst_n = 1'b0;
    #1;
    check("midrun rst cpu_start", cpu_start, 0);
    check("midrun rst start_addr", cpu_start_addr, 0);
    check("midrun rst busy", busy, 0);
    check("midrun rst prog_idx", prog_idx, 0);
    check("midrun rst cycles", cycles, 0);
    check("midrun rst load_ready", load_ready, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    load_one(55);
    exp_q.delete();
    exp_q.push_back('{55, 9, 9, 0});
    run_go("after_rst", 1'b0);

`ifdef PROG_LAUNCH_TIMEOUT_EN
    // First program never finishes: abort at TIMEOUT, second runs normally.
    clear_buf();
    load_one(21);
    load_one(22);
    exp_q.delete();
    exp_q.push_back('{21, 0,  100, 1});
    exp_q.push_back('{22, 15, 15,  1});
    run_go("timeout", 1'b0);
    check("timeout sticky", timeout, 1);
`else
    check("timeout tied low", timeout, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
